lsu: RTL and testbench

- Load/store unit: the memory-access stage directly downstream of ex. Consumes ex's ALU result, store operand and decoded load/store control.
- Non-memory ops: registers the ALU result through to register write-back.
- Loads/stores: runs a request/ready handshake to the data memory, aligns and sign-extends load data, builds byte strobes for stores.
- Asserts `pause` toward pc/ifu while a memory access is outstanding.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 78 +++++++
 rtl/lsu.sv | 129 ++++++++++++
 tb/tb_lsu.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the datapath widths, the RV32I funct3 size codes, the FSM state
// encoding, and a helper that maps funct3 to an access size.
package lsu_pkg;

  localparam int unsigned XLEN_WIDTH = 32;
  localparam int unsigned REG_ADDR   = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Unknown codes fall back to word size.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    lsu_size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Request side (incoming instruction): store data replication, byte strobes,
// and the misalignment check. Response side (captured access): load lane
// extraction with sign or zero extension.
// Ports:
//   req_funct3, req_addr_lo, req_store_data : incoming instruction fields
//   rsp_funct3, rsp_addr_lo, rsp_rdata      : captured access + memory word
//   wdata_c, wstrb_c, misalign_c            : store lanes / alignment result
//   load_data_c                             : aligned, extended load value
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_WIDTH
) (
  input  logic [2:0]      req_funct3,
  input  logic [1:0]      req_addr_lo,
  input  logic [XLEN-1:0] req_store_data,
  input  logic [2:0]      rsp_funct3,
  input  logic [1:0]      rsp_addr_lo,
  input  logic [XLEN-1:0] rsp_rdata,
  output logic [XLEN-1:0] wdata_c,
  output logic [3:0]      wstrb_c,
  output logic            misalign_c,
  output logic [XLEN-1:0] load_data_c
);

  lsu_size_e      req_size;
  lsu_size_e      rsp_size;
  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;

  assign req_size = f3_size(req_funct3);
  assign rsp_size = f3_size(rsp_funct3);

  // Store lanes: data replicated so the strobes alone pick the target bytes.
  always_comb begin
    wdata_c    = req_store_data;
    wstrb_c    = 4'b1111;
    misalign_c = 1'b0;
    case (req_size)
      SZ_B: begin
        wdata_c    = XLEN'({4{req_store_data[7:0]}});
        wstrb_c    = 4'b0001 << req_addr_lo;
        misalign_c = 1'b0;
      end
      SZ_H: begin
        wdata_c    = XLEN'({2{req_store_data[15:0]}});
        wstrb_c    = 4'b0011 << req_addr_lo;
        misalign_c = req_addr_lo[0];
      end
      default: begin
        wdata_c    = req_store_data;
        wstrb_c    = 4'b1111;
        misalign_c = |req_addr_lo;
      end
    endcase
  end

  assign byte_sh   = rsp_rdata >> {rsp_addr_lo, 3'b000};
  assign half_sh   = rsp_rdata >> {rsp_addr_lo[1], 4'b0000};
  assign byte_lane = byte_sh[7:0];
  assign half_lane = half_sh[15:0];

  // Load extract: funct3[2] selects the unsigned variants.
  always_comb begin
    load_data_c = rsp_rdata;
    case (rsp_size)
      SZ_B: load_data_c = rsp_funct3[2] ? XLEN'(byte_lane)
                                        : {{(XLEN-8){byte_lane[7]}}, byte_lane};
      SZ_H: load_data_c = rsp_funct3[2] ? XLEN'(half_lane)
                                        : {{(XLEN-16){half_lane[15]}}, half_lane};
      default: load_data_c = rsp_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: memory-access stage downstream of ex.
// ALU ops are registered straight to write-back; loads/stores run a
// req/ready handshake to data memory while holding pause high.
// Ports:
//   clk, rst                         : clock, async active-low reset
//   in_*                             : instruction from ex
//   pause                            : upstream stall while an access is open
//   mem_req/we/addr/wdata/wstrb      : data memory request (held until ready)
//   mem_ready, mem_rdata             : data memory response
//   wb_en/addr/data                  : register write-back (one-cycle strobe)
//   misalign                         : one-cycle pulse on a misaligned access
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_WIDTH,
  parameter int unsigned REG_AW = REG_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_result,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_en,
  output logic              pause,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [XLEN-1:0]   wb_data,
  output logic              misalign
);

  lsu_state_e        state;
  logic [REG_AW-1:0] cap_rd;
  logic [2:0]        cap_funct3;
  logic [1:0]        cap_addr_lo;

  logic [XLEN-1:0]   wdata_c;
  logic [3:0]        wstrb_c;
  logic              misalign_c;
  logic [XLEN-1:0]   load_data_c;
  logic              is_mem_c;

  assign is_mem_c = in_is_load | in_is_store;

  lsu_align #(.XLEN(XLEN)) u_align (
    .req_funct3     (in_funct3),
    .req_addr_lo    (in_result[1:0]),
    .req_store_data (in_store_data),
    .rsp_funct3     (cap_funct3),
    .rsp_addr_lo    (cap_addr_lo),
    .rsp_rdata      (mem_rdata),
    .wdata_c        (wdata_c),
    .wstrb_c        (wstrb_c),
    .misalign_c     (misalign_c),
    .load_data_c    (load_data_c)
  );

  // FSM with registered outputs; wb_en and misalign default low so they pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      pause       <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      wb_en       <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      misalign    <= 1'b0;
      cap_rd      <= '0;
      cap_funct3  <= '0;
      cap_addr_lo <= '0;
    end else begin
      wb_en    <= 1'b0;
      misalign <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (!is_mem_c) begin
              wb_en   <= in_rd_en & (in_rd != '0);
              wb_addr <= in_rd;
              wb_data <= in_result;
            end else if (misalign_c) begin
              misalign <= 1'b1;
            end else begin
              // Store wins if both flags are set.
              mem_req     <= 1'b1;
              mem_we      <= in_is_store;
              mem_addr    <= {in_result[XLEN-1:2], 2'b00};
              mem_wdata   <= in_is_store ? wdata_c : '0;
              mem_wstrb   <= in_is_store ? wstrb_c : 4'b0000;
              pause       <= 1'b1;
              cap_rd      <= in_rd;
              cap_funct3  <= in_funct3;
              cap_addr_lo <= in_result[1:0];
              state       <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            pause   <= 1'b0;
            state   <= ST_IDLE;
            if (!mem_we) begin
              wb_en   <= (cap_rd != '0);
              wb_addr <= cap_rd;
              wb_data <= load_data_c;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases followed by random ALU, load
// and store traffic, checked against a size/offset arithmetic model.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        in_rd_en;
  logic        pause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  lsu dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_is_load    (in_is_load),
    .in_is_store   (in_is_store),
    .in_funct3     (in_funct3),
    .in_result     (in_result),
    .in_store_data (in_store_data),
    .in_rd         (in_rd),
    .in_rd_en      (in_rd_en),
    .pause         (pause),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .misalign      (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Access size in bytes; unknown codes behave as a word.
  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  // One instruction end to end; memory answers after wait_n stall cycles.
  task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] rd, input bit rd_en,
                       input int wait_n, input logic [31:0] rdata);
    int          size;
    int          off;
    bit          mem;
    bit          is_ld;
    bit          mis;
    bit          sgn;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    logic [3:0]  exp_ws;
    logic [31:0] sh;
    logic [31:0] mask;
    logic [31:0] exp_ld;

    size     = size_of(f3);
    off      = int'(addr[1:0]);
    mem      = ld || st;
    is_ld    = ld && !st;
    mis      = mem && ((off % size) != 0);
    exp_addr = addr - 32'(off);

    @(negedge clk);
    in_valid      = 1'b1;
    in_is_load    = ld;
    in_is_store   = st;
    in_funct3     = f3;
    in_result     = addr;
    in_store_data = sd;
    in_rd         = rd;
    in_rd_en      = rd_en;
    mem_ready     = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;

    if (!mem) begin
      check("alu_wb_en", 32'(wb_en), 32'(rd_en && rd != 5'd0));
      check("alu_wb_addr", 32'(wb_addr), 32'(rd));
      check("alu_wb_data", wb_data, addr);
      check("alu_pause", 32'(pause), 32'd0);
      check("alu_req", 32'(mem_req), 32'd0);
      @(negedge clk);
      check("alu_wb_pulse", 32'(wb_en), 32'd0);
    end else if (mis) begin
      check("mis_pulse", 32'(misalign), 32'd1);
      check("mis_req", 32'(mem_req), 32'd0);
      check("mis_wb", 32'(wb_en), 32'd0);
      check("mis_pause", 32'(pause), 32'd0);
      @(negedge clk);
      check("mis_clear", 32'(misalign), 32'd0);
      check("mis_req2", 32'(mem_req), 32'd0);
    end else begin
      check("acc_req", 32'(mem_req), 32'd1);
      check("acc_pause", 32'(pause), 32'd1);
      check("acc_we", 32'(mem_we), 32'(st));
      check("acc_addr", mem_addr, exp_addr);
      check("acc_wb", 32'(wb_en), 32'd0);
      if (st) begin
        if (size == 1)      exp_wd = 32'(sd[7:0]) * 32'h0101_0101;
        else if (size == 2) exp_wd = 32'(sd[15:0]) * 32'h0001_0001;
        else                exp_wd = sd;
        if (size == 4) exp_ws = 4'hF;
        else           exp_ws = 4'(((1 << size) - 1) << off);
        check("st_wdata", mem_wdata, exp_wdata_fix(exp_wd));
        check("st_wstrb", 32'(mem_wstrb), 32'(exp_ws));
      end else begin
        check("ld_wstrb", 32'(mem_wstrb), 32'd0);
      end
      for (int i = 0; i < wait_n; i++) begin
        // Upstream noise while stalled must be ignored.
        in_valid    = 1'($urandom);
        in_is_load  = 1'($urandom);
        in_is_store = 1'($urandom);
        in_funct3   = 3'($urandom);
        in_result   = $urandom;
        in_rd       = 5'($urandom);
        in_rd_en    = 1'b1;
        mem_rdata   = $urandom;
        mem_ready   = 1'b0;
        @(negedge clk);
        check("hold_req", 32'(mem_req), 32'd1);
        check("hold_pause", 32'(pause), 32'd1);
        check("hold_addr", mem_addr, exp_addr);
        check("hold_wb", 32'(wb_en), 32'd0);
      end
      in_valid  = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = rdata;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      check("done_req", 32'(mem_req), 32'd0);
      check("done_pause", 32'(pause), 32'd0);
      check("done_wb_en", 32'(wb_en), 32'(is_ld && rd != 5'd0));
      if (is_ld && rd != 5'd0) begin
        sh   = rdata >> (8 * off);
        sgn  = (f3 == 3'b000 || f3 == 3'b001);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        exp_ld = sh & mask;
        if (sgn && sh[8 * size - 1]) exp_ld = exp_ld | ~mask;
        check("ld_wb_addr", 32'(wb_addr), 32'(rd));
        check("ld_wb_data", wb_data, exp_ld);
      end
      @(negedge clk);
      check("done_wb_pulse", 32'(wb_en), 32'd0);
    end
  endtask

  function automatic logic [31:0] exp_wdata_fix(input logic [31:0] v);
    return v;
  endfunction

  initial begin
    rst           = 1'b0;
    in_valid      = 1'b0;
    in_is_load    = 1'b0;
    in_is_store   = 1'b0;
    in_funct3     = 3'd0;
    in_result     = 32'd0;
    in_store_data = 32'd0;
    in_rd         = 5'd0;
    in_rd_en      = 1'b0;
    mem_ready     = 1'b0;
    mem_rdata     = 32'd0;

    #1;
    check("rst_pause", 32'(pause), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_mis", 32'(misalign), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed cases.
    issue(0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 32'h0);
    issue(0, 0, 3'b000, 32'h0000_5555, 32'h0, 5'd0, 1, 0, 32'h0);
    issue(0, 0, 3'b000, 32'h0000_7777, 32'h0, 5'd3, 0, 0, 32'h0);
    issue(1, 0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1, 3, 32'h80FF_0000);
    issue(0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 0, 1, 32'h0);
    issue(1, 0, 3'b101, 32'h0000_0202, 32'h0, 5'd9, 1, 0, 32'hABCD_0000);
    issue(1, 0, 3'b010, 32'h0000_0101, 32'h0, 5'd4, 1, 0, 32'h0);
    issue(0, 1, 3'b001, 32'h0000_0103, 32'h1111, 5'd0, 0, 0, 32'h0);
    issue(1, 0, 3'b010, 32'h0000_0200, 32'h0, 5'd0, 1, 0, 32'hDEAD_BEEF);
    issue(1, 0, 3'b010, 32'h0000_0204, 32'h0, 5'd1, 1, 0, 32'hDEAD_BEEF);
    issue(0, 1, 3'b000, 32'h0000_0302, 32'h0000_00A5, 5'd0, 0, 2, 32'h0);
    issue(1, 1, 3'b010, 32'h0000_0400, 32'h1234_5678, 5'd6, 1, 1, 32'h0);
    issue(1, 0, 3'b011, 32'h0000_0400, 32'h0, 5'd8, 1, 0, 32'hCAFE_F00D);
    issue(1, 0, 3'b110, 32'h0000_0402, 32'h0, 5'd8, 1, 0, 32'hCAFE_F00D);
    issue(1, 0, 3'b001, 32'h0000_0406, 32'h0, 5'd10, 1, 1, 32'h8001_7FFF);

    // Reset during an outstanding store.
    @(negedge clk);
    in_valid      = 1'b1;
    in_is_load    = 1'b0;
    in_is_store   = 1'b1;
    in_funct3     = 3'b000;
    in_result     = 32'h0000_0301;
    in_store_data = 32'h0000_005A;
    in_rd         = 5'd0;
    in_rd_en      = 1'b0;
    mem_ready     = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("rsta_req_before", 32'(mem_req), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rsta_req", 32'(mem_req), 32'd0);
    check("rsta_pause", 32'(pause), 32'd0);
    check("rsta_wb", 32'(wb_en), 32'd0);
    check("rsta_wstrb", 32'(mem_wstrb), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    issue(0, 0, 3'b000, 32'h0000_4321, 32'h0, 5'd12, 1, 0, 32'h0);

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      int          kind;
      logic [2:0]  f3;
      logic [31:0] a;
      kind = int'($urandom_range(0, 2));
      a    = $urandom;
      if (kind == 0) begin
        issue(0, 0, 3'($urandom), a, $urandom, 5'($urandom), 1'($urandom), 0, 32'h0);
      end else if (kind == 1) begin
        case ($urandom_range(0, 7))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          4: f3 = 3'b101;
          5: f3 = 3'b011;
          6: f3 = 3'b110;
          default: f3 = 3'b111;
        endcase
        issue(1, 0, f3, a, $urandom, 5'($urandom), 1, int'($urandom_range(0, 3)), $urandom);
      end else begin
        f3 = 3'($urandom_range(0, 2));
        issue(0, 1, f3, a, $urandom, 5'($urandom), 0, int'($urandom_range(0, 3)), 32'h0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
